// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite data-memory slave.
//   dmem_state_e : slave FSM states
//   RespOkay / RespSlverr : AXI response codes
//   word_index() : zero-extends an 8-bit word index to the 12-bit memory address
package axi_lite_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrIssue,
    StWrResp,
    StRdWait,
    StRdResp
  } dmem_state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  function automatic logic [11:0] word_index(input logic [7:0] idx);
    return {4'b0000, idx};
  endfunction

endpackage

// File: rtl/axi_lite_dmem_slave.sv
// AXI4-Lite slave fronting a single-port, 32-bit-wide synchronous data memory.
//
// Write path: AW and W are latched independently; once both are held the slave
// issues a one-cycle mem_write, then returns B. Reads are accepted only when no
// write is pending or being offered. The memory returns read_data one clock after
// read_addr; it is captured into s_rdata and held until the master takes R.
//
// Ports
//   clk, rst                    : clock, asynchronous active-high reset
//   s_aw*, s_w*, s_b*           : AXI4-Lite write channels
//   s_ar*, s_r*                 : AXI4-Lite read channels
//   mem_write, byte_en          : write strobe and byte lanes to the memory
//   write_addr, read_addr       : 12-bit word indices, taken from byte address [9:2]
//   write_data, read_data       : memory write word / memory read word
//
// Build option: define DMEM_AXI_ERR_EN to reject byte addresses >= MEM_WORDS*4
// with SLVERR (writes suppressed, reads return zero). Without it the upper
// address bits are ignored and every access is answered OKAY.
module axi_lite_dmem_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              mem_write,
  output logic [3:0]        byte_en,
  output logic [11:0]       write_addr,
  output logic [11:0]       read_addr,
  output logic [31:0]       write_data,
  input  logic [31:0]       read_data
);

`ifdef DMEM_AXI_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  localparam logic [31:0] ByteLimit = 32'(MEM_WORDS * 4);

  dmem_state_e state_q;
  logic        aw_vld_q, w_vld_q;
  logic        aw_err_q, ar_err_q;
  logic        rd_wait_q;
  logic        mem_write_q;
  logic [3:0]  byte_en_q;
  logic [11:0] write_addr_q, read_addr_q;
  logic [31:0] write_data_q, rdata_q;
  logic [1:0]  bresp_q, rresp_q;
  logic        bvalid_q, rvalid_q;

  logic aw_hs, w_hs, ar_hs;
  logic aw_oor, ar_oor;
  logic idle;

  assign idle = (state_q == StIdle);

  // Readies are gated by rst so they read 0 while reset is held.
  assign s_awready = ~rst & idle & ~aw_vld_q;
  assign s_wready  = ~rst & idle & ~w_vld_q;
  // Writes win: a read is only taken when no write is latched or being offered.
  assign s_arready = ~rst & idle & ~aw_vld_q & ~w_vld_q & ~s_awvalid & ~s_wvalid;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign ar_hs = s_arvalid & s_arready;

  assign aw_oor = ErrEn & (32'(s_awaddr) >= ByteLimit);
  assign ar_oor = ErrEn & (32'(s_araddr) >= ByteLimit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      aw_vld_q     <= 1'b0;
      w_vld_q      <= 1'b0;
      aw_err_q     <= 1'b0;
      ar_err_q     <= 1'b0;
      rd_wait_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      byte_en_q    <= 4'b0000;
      write_addr_q <= 12'h000;
      read_addr_q  <= 12'h000;
      write_data_q <= 32'h0;
      rdata_q      <= 32'h0;
      bresp_q      <= RespOkay;
      rresp_q      <= RespOkay;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
    end else begin
      mem_write_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (aw_vld_q && w_vld_q) begin
            state_q     <= StWrIssue;
            mem_write_q <= ~aw_err_q;
          end else begin
            if (aw_hs) begin
              aw_vld_q     <= 1'b1;
              aw_err_q     <= aw_oor;
              write_addr_q <= word_index(s_awaddr[9:2]);
            end
            if (w_hs) begin
              w_vld_q      <= 1'b1;
              write_data_q <= s_wdata;
              byte_en_q    <= s_wstrb;
            end
            if (ar_hs) begin
              state_q     <= StRdWait;
              ar_err_q    <= ar_oor;
              rd_wait_q   <= 1'b0;
              read_addr_q <= word_index(s_araddr[9:2]);
            end
          end
        end
        StWrIssue: begin
          state_q  <= StWrResp;
          bvalid_q <= 1'b1;
          bresp_q  <= aw_err_q ? RespSlverr : RespOkay;
        end
        StWrResp: begin
          if (s_bready) begin
            state_q  <= StIdle;
            bvalid_q <= 1'b0;
            aw_vld_q <= 1'b0;
            w_vld_q  <= 1'b0;
          end
        end
        StRdWait: begin
          // First cycle lets the memory register read_addr; data is valid on the second.
          if (!rd_wait_q) begin
            rd_wait_q <= 1'b1;
          end else begin
            state_q  <= StRdResp;
            rvalid_q <= 1'b1;
            rdata_q  <= ar_err_q ? 32'h0 : read_data;
            rresp_q  <= ar_err_q ? RespSlverr : RespOkay;
          end
        end
        StRdResp: begin
          if (s_rready) begin
            state_q  <= StIdle;
            rvalid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_write  = mem_write_q;
  assign byte_en    = byte_en_q;
  assign write_addr = write_addr_q;
  assign read_addr  = read_addr_q;
  assign write_data = write_data_q;
  assign s_rdata    = rdata_q;
  assign s_rresp    = rresp_q;
  assign s_rvalid   = rvalid_q;
  assign s_bresp    = bresp_q;
  assign s_bvalid   = bvalid_q;

endmodule

// File: tb/tb_axi_lite_dmem_slave.sv
// Bench for axi_lite_dmem_slave: DUT plus a behavioural synchronous data memory,
// a reference memory model feeding expectation queues, and scenario tasks.
module tb_axi_lite_dmem_slave;

  logic        clk, rst;
  logic [11:0] s_awaddr, s_araddr;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb, byte_en;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic        mem_write;
  logic [11:0] write_addr, read_addr;
  logic [31:0] write_data, read_data;

  axi_lite_dmem_slave #(.ADDR_W(12), .MEM_WORDS(256)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_write(mem_write), .byte_en(byte_en), .write_addr(write_addr),
    .read_addr(read_addr), .write_data(write_data), .read_data(read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached memory: byte-lane writes, registered read (one clock after read_addr).
  logic [31:0] dmem [256];
  logic        init_mem;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 32'h0;
    end else if (mem_write) begin
      for (int b = 0; b < 4; b++)
        if (byte_en[b]) dmem[write_addr[7:0]][8*b +: 8] <= write_data[8*b +: 8];
    end
    read_data <= dmem[read_addr[7:0]];
  end

  // Reference model and expectation queues.
  typedef struct {
    bit          issue;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [1:0]  resp;
  } wr_exp_t;
  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  wr_exp_t     wr_q[$];
  rd_exp_t     rd_q[$];
  logic [31:0] ref_mem [256];
  int          n_chk, n_pass;

  function automatic bit model_oor(input logic [11:0] a);
`ifdef DMEM_AXI_ERR_EN
    return a >= 12'h400;
`else
    return (a != a);
`endif
  endfunction

  function automatic void model_write(input logic [11:0] a, input logic [31:0] d,
                                     input logic [3:0] s);
    wr_exp_t e;
    logic [7:0] idx;
    idx = a[9:2];
    e.issue = !model_oor(a);
    e.addr  = {4'h0, idx};
    e.data  = d;
    e.be    = s;
    e.resp  = model_oor(a) ? 2'b10 : 2'b00;
    if (e.issue)
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    wr_q.push_back(e);
  endfunction

  function automatic void model_read(input logic [11:0] a);
    rd_exp_t e;
    logic [7:0] idx;
    idx = a[9:2];
    e.data = model_oor(a) ? 32'h0 : ref_mem[idx];
    e.resp = model_oor(a) ? 2'b10 : 2'b00;
    rd_q.push_back(e);
  endfunction

  // Observations from the last transaction (cycle numbers count negedges from start).
  int          o_mw_cnt, o_mw_cyc, o_wr_hs_cyc, o_b_cyc, o_ar_hs_cyc, o_r_cyc, o_r_vcyc;
  logic [11:0] o_wa;
  logic [31:0] o_wd, o_rdata;
  logic [3:0]  o_be;
  logic [1:0]  o_bresp, o_rresp;
  bit          o_r_unstable, o_timeout;
  logic        o_ar_rdy0, o_valid_after;

  // Drives one optional write and one optional read concurrently; records only.
  task automatic axi_txn(input bit do_wr, input logic [11:0] waddr, input logic [31:0] wdat,
                         input logic [3:0] wstb, input int aw_dly, input int w_dly,
                         input bit do_rd, input logic [11:0] raddr, input int r_hold);
    bit aw_done, w_done, b_done, ar_done, r_done;
    int cyc;
    aw_done = !do_wr; w_done = !do_wr; b_done = !do_wr;
    ar_done = !do_rd; r_done = !do_rd;
    cyc = 0;
    o_mw_cnt = 0; o_mw_cyc = -1; o_wr_hs_cyc = -1; o_b_cyc = -1;
    o_ar_hs_cyc = -1; o_r_cyc = -1; o_r_vcyc = 0; o_r_unstable = 0; o_ar_rdy0 = 1'bx;
    while (!(b_done && r_done) && cyc < 100) begin
      if (mem_write) begin
        o_mw_cnt++; o_mw_cyc = cyc; o_wa = write_addr; o_wd = write_data; o_be = byte_en;
      end
      if (do_wr && s_bvalid && !b_done) begin
        o_b_cyc = cyc; o_bresp = s_bresp; b_done = 1'b1;
      end
      if (do_rd && !r_done && s_rvalid) begin
        if (o_r_cyc < 0) begin
          o_r_cyc = cyc; o_rdata = s_rdata; o_rresp = s_rresp;
        end else if (s_rdata !== o_rdata) begin
          o_r_unstable = 1'b1;
        end
        o_r_vcyc++;
        if (cyc - o_r_cyc >= r_hold) r_done = 1'b1;
      end else if (do_rd && !r_done && o_r_cyc >= 0) begin
        o_r_unstable = 1'b1;
      end
      s_bready  = do_wr;
      s_rready  = (o_r_cyc >= 0) && r_done;
      s_awvalid = !aw_done && cyc >= aw_dly; s_awaddr = waddr;
      s_wvalid  = !w_done && cyc >= w_dly;   s_wdata = wdat; s_wstrb = wstb;
      s_arvalid = !ar_done;                  s_araddr = raddr;
      #1;
      if (cyc == 0) o_ar_rdy0 = s_arready;
      if (s_awvalid && s_awready) begin aw_done = 1'b1; if (w_done) o_wr_hs_cyc = cyc; end
      if (s_wvalid && s_wready) begin w_done = 1'b1; if (aw_done) o_wr_hs_cyc = cyc; end
      if (s_arvalid && s_arready) begin ar_done = 1'b1; o_ar_hs_cyc = cyc; end
      @(negedge clk);
      cyc++;
    end
    o_timeout = !(b_done && r_done);
    o_valid_after = s_bvalid | s_rvalid;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; s_bready = 1'b0; s_rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_chk++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, mem_write} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000",
               {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, mem_write});
    else n_pass++;
    n_chk++;
    if ({byte_en, write_addr, read_addr, write_data, s_rdata, s_bresp, s_rresp} !== '0)
      $display("FAIL reset_data: got %h want 0",
               {byte_en, write_addr, read_addr, write_data, s_rdata, s_bresp, s_rresp});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if ({s_awready, s_wready, s_arready} !== 3'b111)
      $display("FAIL reset_idle_ready: got %b want 111", {s_awready, s_wready, s_arready});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_write_same_cycle();
    wr_exp_t we;
    model_write(12'h010, 32'hDEADBEEF, 4'hF);
    axi_txn(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 1'b0, 12'h0, 0);
    we = wr_q.pop_front();
    n_chk++;
    if (o_timeout) $display("FAIL wr_same_timeout: got timeout=1 want 0"); else n_pass++;
    n_chk++;
    if (o_mw_cnt !== 1) $display("FAIL wr_same_mw_count: got %0d want 1", o_mw_cnt);
    else n_pass++;
    n_chk++;
    if ({o_wa, o_wd, o_be} !== {we.addr, we.data, we.be})
      $display("FAIL wr_same_mem_port: got %h/%h/%h want %h/%h/%h",
               o_wa, o_wd, o_be, we.addr, we.data, we.be);
    else n_pass++;
    n_chk++;
    if (o_bresp !== we.resp) $display("FAIL wr_same_bresp: got %b want %b", o_bresp, we.resp);
    else n_pass++;
    // Handshake edge, WR_ISSUE one edge later, B valid two edges later.
    n_chk++;
    if (o_mw_cyc !== o_wr_hs_cyc + 2)
      $display("FAIL wr_same_mw_latency: got %0d want %0d", o_mw_cyc, o_wr_hs_cyc + 2);
    else n_pass++;
    n_chk++;
    if (o_b_cyc !== o_wr_hs_cyc + 3)
      $display("FAIL wr_same_b_latency: got %0d want %0d", o_b_cyc, o_wr_hs_cyc + 3);
    else n_pass++;
    n_chk++;
    if (o_valid_after !== 1'b0) $display("FAIL wr_same_b_drop: got %b want 0", o_valid_after);
    else n_pass++;
  endtask

  task automatic test_write_w_first();
    wr_exp_t we;
    rd_exp_t re;
    model_write(12'h010, 32'h000000AA, 4'h1);
    axi_txn(1'b1, 12'h010, 32'h000000AA, 4'h1, 3, 0, 1'b0, 12'h0, 0);
    we = wr_q.pop_front();
    n_chk++;
    if (o_mw_cnt !== 1) $display("FAIL w_first_mw_count: got %0d want 1", o_mw_cnt);
    else n_pass++;
    n_chk++;
    if (o_mw_cyc !== 5) $display("FAIL w_first_mw_cycle: got %0d want 5", o_mw_cyc);
    else n_pass++;
    n_chk++;
    if ({o_wa, o_be} !== {we.addr, we.be})
      $display("FAIL w_first_addr_be: got %h/%h want %h/%h", o_wa, o_be, we.addr, we.be);
    else n_pass++;
    n_chk++;
    if (o_b_cyc !== 6) $display("FAIL w_first_b_cycle: got %0d want 6", o_b_cyc); else n_pass++;
    model_read(12'h010);
    axi_txn(1'b0, 12'h0, 32'h0, 4'h0, 0, 0, 1'b1, 12'h010, 0);
    re = rd_q.pop_front();
    n_chk++;
    if (o_rdata !== re.data) $display("FAIL w_first_readback: got %h want %h", o_rdata, re.data);
    else n_pass++;
    n_chk++;
    if (o_rresp !== re.resp) $display("FAIL w_first_rresp: got %b want %b", o_rresp, re.resp);
    else n_pass++;
    n_chk++;
    if (o_r_cyc !== o_ar_hs_cyc + 3)
      $display("FAIL rd_latency: got %0d want %0d", o_r_cyc, o_ar_hs_cyc + 3);
    else n_pass++;
    n_chk++;
    if (o_mw_cnt !== 0) $display("FAIL rd_no_mem_write: got %0d want 0", o_mw_cnt); else n_pass++;
  endtask

  task automatic test_read_stall();
    rd_exp_t re;
    model_read(12'h010);
    axi_txn(1'b0, 12'h0, 32'h0, 4'h0, 0, 0, 1'b1, 12'h010, 5);
    re = rd_q.pop_front();
    n_chk++;
    if (o_rdata !== re.data) $display("FAIL stall_rdata: got %h want %h", o_rdata, re.data);
    else n_pass++;
    n_chk++;
    if (o_r_unstable) $display("FAIL stall_hold: got unstable=1 want 0"); else n_pass++;
    n_chk++;
    if (o_r_vcyc !== 6) $display("FAIL stall_valid_cycles: got %0d want 6", o_r_vcyc);
    else n_pass++;
    n_chk++;
    if (o_valid_after !== 1'b0) $display("FAIL stall_r_drop: got %b want 0", o_valid_after);
    else n_pass++;
  endtask

  task automatic test_write_priority();
    wr_exp_t we;
    rd_exp_t re;
    model_write(12'h020, 32'h12345678, 4'hF);
    model_read(12'h020);
    axi_txn(1'b1, 12'h020, 32'h12345678, 4'hF, 0, 0, 1'b1, 12'h020, 0);
    we = wr_q.pop_front();
    re = rd_q.pop_front();
    n_chk++;
    if (o_timeout) $display("FAIL prio_timeout: got timeout=1 want 0"); else n_pass++;
    n_chk++;
    if (o_ar_rdy0 !== 1'b0) $display("FAIL prio_arready: got %b want 0", o_ar_rdy0);
    else n_pass++;
    n_chk++;
    if (!(o_ar_hs_cyc > o_b_cyc))
      $display("FAIL prio_order: got ar_hs=%0d b=%0d want ar_hs>b", o_ar_hs_cyc, o_b_cyc);
    else n_pass++;
    n_chk++;
    if ({o_mw_cnt == 1, o_wa} !== {1'b1, we.addr})
      $display("FAIL prio_write: got cnt=%0d addr=%h want 1/%h", o_mw_cnt, o_wa, we.addr);
    else n_pass++;
    n_chk++;
    if (o_rdata !== re.data) $display("FAIL prio_rdata: got %h want %h", o_rdata, re.data);
    else n_pass++;
  endtask

  task automatic test_strobe_zero();
    wr_exp_t we;
    rd_exp_t re;
    model_write(12'h030, 32'hFFFFFFFF, 4'h0);
    axi_txn(1'b1, 12'h030, 32'hFFFFFFFF, 4'h0, 1, 0, 1'b0, 12'h0, 0);
    we = wr_q.pop_front();
    n_chk++;
    if (o_mw_cnt !== 1) $display("FAIL strb0_mw_count: got %0d want 1", o_mw_cnt); else n_pass++;
    n_chk++;
    if (o_be !== we.be) $display("FAIL strb0_byte_en: got %h want %h", o_be, we.be);
    else n_pass++;
    model_read(12'h030);
    axi_txn(1'b0, 12'h0, 32'h0, 4'h0, 0, 0, 1'b1, 12'h030, 0);
    re = rd_q.pop_front();
    n_chk++;
    if (o_rdata !== re.data) $display("FAIL strb0_readback: got %h want %h", o_rdata, re.data);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    wr_exp_t we;
    rd_exp_t re;
    model_write(12'h400, 32'hCAFEF00D, 4'hF);
    axi_txn(1'b1, 12'h400, 32'hCAFEF00D, 4'hF, 0, 2, 1'b0, 12'h0, 0);
    we = wr_q.pop_front();
    n_chk++;
    if (o_mw_cnt !== int'(we.issue))
      $display("FAIL oor_mw_count: got %0d want %0d", o_mw_cnt, we.issue);
    else n_pass++;
    n_chk++;
    if (o_bresp !== we.resp) $display("FAIL oor_bresp: got %b want %b", o_bresp, we.resp);
    else n_pass++;
    n_chk++;
    if (o_b_cyc !== o_wr_hs_cyc + 3)
      $display("FAIL oor_b_latency: got %0d want %0d", o_b_cyc, o_wr_hs_cyc + 3);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      logic [11:0] ra;
      ra = (k == 0) ? 12'h000 : 12'h400;
      model_read(ra);
      axi_txn(1'b0, 12'h0, 32'h0, 4'h0, 0, 0, 1'b1, ra, 1);
      re = rd_q.pop_front();
      n_chk++;
      if ({o_rdata, o_rresp} !== {re.data, re.resp})
        $display("FAIL oor_read_%h: got %h/%b want %h/%b", ra, o_rdata, o_rresp, re.data, re.resp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_op();
    rd_exp_t re;
    int mw_seen;
    mw_seen = 0;
    s_araddr = 12'h010; s_arvalid = 1'b1;
    #1;
    n_chk++;
    if (s_arready !== 1'b1) $display("FAIL rst_op_arready: got %b want 1", s_arready);
    else n_pass++;
    @(negedge clk);
    s_arvalid = 1'b0;
    #1;
    n_chk++;
    if (read_addr !== 12'h004) $display("FAIL rst_op_read_addr: got %h want 004", read_addr);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, mem_write, byte_en, write_addr,
         read_addr, write_data, s_rdata, s_bresp, s_rresp} !== '0)
      $display("FAIL rst_op_outputs: got %h want 0",
               {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, mem_write, byte_en,
                write_addr, read_addr, write_data, s_rdata, s_bresp, s_rresp});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    // Latch AW and W, then reset before the write can issue.
    s_awaddr = 12'h050; s_awvalid = 1'b1;
    s_wdata = 32'h55555555; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_write) mw_seen++;
    end
    n_chk++;
    if (mw_seen !== 0) $display("FAIL rst_op_abandon_write: got %0d want 0", mw_seen);
    else n_pass++;
    n_chk++;
    if ({s_awready, s_wready} !== 2'b11)
      $display("FAIL rst_op_flags_clear: got %b want 11", {s_awready, s_wready});
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      logic [11:0] ra;
      ra = (k == 0) ? 12'h010 : 12'h050;
      model_read(ra);
      axi_txn(1'b0, 12'h0, 32'h0, 4'h0, 0, 0, 1'b1, ra, 0);
      re = rd_q.pop_front();
      n_chk++;
      if ({o_timeout, o_rdata, o_rresp} !== {1'b0, re.data, re.resp})
        $display("FAIL rst_op_read_%h: got to=%b %h/%b want to=0 %h/%b",
                 ra, o_timeout, o_rdata, o_rresp, re.data, re.resp);
      else n_pass++;
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; init_mem = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    init_mem = 1'b0;
    test_reset();
    test_write_same_cycle();
    test_write_w_first();
    test_read_stall();
    test_write_priority();
    test_strobe_zero();
    test_out_of_range();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_lite_dmem_slave.md
AXI_LITE_DMEM_SLAVE -- requirements
Module: axi_lite_dmem_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning AXI byte-address width.
REQ-002 SHALL have parameter MEM_WORDS, default 256, meaning number of 32-bit words in the attached data memory.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_awaddr  in  ADDR_W  write byte address.
- s_awvalid  in  1 / s_awready  out  1.
- s_wdata  in  32 / s_wstrb  in  4.
- s_wvalid  in  1 / s_wready  out  1.
- s_bresp  out  2 / s_bvalid  out  1 / s_bready  in  1.
- s_araddr  in  ADDR_W  read byte address.
- s_arvalid  in  1 / s_arready  out  1.
- s_rdata  out  32 / s_rresp  out  2 / s_rvalid  out  1 / s_rready  in  1.
- mem_write  out  1  one-cycle write strobe to the data memory.
- byte_en  out  4  byte lanes for mem_write.
- write_addr  out  12  word index, {zero-extend, awaddr[9:2]}.
- read_addr  out  12  word index, {zero-extend, araddr[9:2]}.
- write_data  out  32  write word.
- read_data  in  32  memory output, valid exactly one clk after read_addr is presented.

Function
REQ-004 SHALL implement FSM states IDLE, WR_ISSUE, WR_RESP, RD_WAIT, RD_RESP.
REQ-005 SHALL, in IDLE, assert s_awready while no AW is latched and s_wready while no W is latched; each channel is latched independently on valid&ready.
REQ-006 SHALL go IDLE->WR_ISSUE in the cycle after both AW and W are latched (same-cycle handshakes allowed).
REQ-007 SHALL, in WR_ISSUE, drive mem_write=1 for exactly one cycle with latched address, data and byte_en=wstrb, then go to WR_RESP.
REQ-008 SHALL hold s_bvalid=1 in WR_RESP until s_bready, then return to IDLE and clear both latch flags.
REQ-009 SHALL assert s_arready in IDLE only when no AW or W is latched and neither s_awvalid nor s_wvalid is high (writes have priority).
REQ-010 SHALL, on AR handshake, register read_addr and go to RD_WAIT; next cycle capture read_data into s_rdata and go to RD_RESP.
REQ-011 SHALL hold s_rvalid=1 and s_rdata stable in RD_RESP until s_rready, then return to IDLE.
REQ-012 SHALL keep mem_write=0 in every state except WR_ISSUE; strobe 4'b0000 still produces a one-cycle mem_write with byte_en=0.
REQ-013 SHALL drive s_bresp/s_rresp OKAY (2'b00) unless REQ-017 applies.
REQ-014 SHALL give read latency AR-handshake to s_rvalid of 2 cycles and write latency last-of-AW/W-handshake to s_bvalid of 2 cycles.

Reset
REQ-015 SHALL, on rst=1, asynchronously enter IDLE, clear latch flags, and drive all ready/valid outputs, mem_write, byte_en, addresses, write_data, s_rdata and resp outputs to 0.
REQ-016 SHALL abandon any in-flight transaction on reset mid-operation without issuing a mem_write.

Configuration
REQ-017 SHALL, with DMEM_AXI_ERR_EN defined, flag byte addresses >= MEM_WORDS*4 as out-of-range: write suppresses mem_write (WR_ISSUE still one cycle) and returns SLVERR (2'b10); read returns SLVERR with s_rdata=0.
REQ-018 SHALL, without DMEM_AXI_ERR_EN, ignore address bits above [9:2] (wrap modulo MEM_WORDS) and always respond OKAY.

Structure
REQ-019 SHALL place the FSM state enum and AXI response constants (OKAY, SLVERR) in shared package axi_lite_pkg.
REQ-020 SHALL be a single module with no sub-modules; the data memory is instantiated alongside it by the integrating top level.

Verification
REQ-021 Write awaddr=0x010, wdata=0xDEADBEEF, wstrb=4'hF, same cycle -> one mem_write with write_addr=4, byte_en=F; bresp=OKAY two cycles later.
REQ-022 W first (wdata=0x000000AA, wstrb=4'h1), AW 3 cycles later (awaddr=0x010) -> single mem_write after AW, byte_en=1; readback of 0x010 gives 0xDEADBEAA.
REQ-023 Read araddr=0x010 with s_rready low for 5 cycles -> s_rvalid held, s_rdata stable at 0xDEADBEAA until s_rready.
REQ-024 AR and AW+W valid in the same IDLE cycle -> write completes first, then read is accepted and returns the new data.
REQ-025 With DMEM_AXI_ERR_EN, write awaddr=0x400 -> no mem_write, bresp=2'b10; without it, same write lands at word 0.
REQ-026 Assert rst during RD_WAIT -> all outputs 0 immediately; next read transaction completes normally.
